// File: rtl/qspi_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : qspi_mem_responder_if
// Purpose  : Quad-SPI pad bundle plus the synchronous byte-RAM port.
// Revision : 1.0 - initial release
// ============================================================================
interface qspi_mem_responder_if #(
    parameter int ADDR_BITS = 16
);
    logic                 spi_sck;
    logic                 spi_cs_n;
    logic [3:0]           spi_io_in;
    logic [3:0]           spi_io_out;
    logic [3:0]           spi_io_oe;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_re;
    logic [7:0]           mem_rdata;
    logic                 mem_we;
    logic [7:0]           mem_wdata;

    modport slave (
        input  spi_sck, spi_cs_n, spi_io_in, mem_rdata,
        output spi_io_out, spi_io_oe, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output spi_sck, spi_cs_n, spi_io_in, mem_rdata,
        input  spi_io_out, spi_io_oe, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/qspi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : qspi_mem_responder
// Purpose  : Quad-SPI flash/PSRAM emulator serving EB reads / 38 writes from
//            a byte RAM. Optional JEDEC ID (9F) when QSPI_RESP_ID_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_mem_responder #(
    parameter int          ADDR_BITS     = 16,
    parameter int          DUMMY_NIBBLES = 4,
    parameter logic [23:0] JEDEC_ID      = 24'hC0_FFEE
) (
    input wire logic            clk,
    input wire logic            reset,
    qspi_mem_responder_if.slave bus
);

`ifdef QSPI_RESP_ID_EN
    localparam logic c_ID_EN = 1'b1;
`else
    localparam logic c_ID_EN = 1'b0;
`endif

    localparam logic [7:0] c_CMD_READ  = 8'hEB;
    localparam logic [7:0] c_CMD_WRITE = 8'h38;
    localparam logic [7:0] c_CMD_ID    = 8'h9F;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_RDATA  = 3'd4,
        S_WDATA  = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sck_sync;
    logic [1:0]           r_cs_sync;
    logic [3:0]           r_io_sync0;
    logic [3:0]           r_io_sync1;
    logic                 r_sck_prev;
    logic                 r_cs_prev;
    logic [7:0]           r_cnt;
    logic [3:0]           r_cmd_hi;
    logic                 r_write;
    logic                 r_id_mode;
    logic [1:0]           r_id_idx;
    logic [ADDR_BITS-1:0] r_addr;
    logic [3:0]           r_wnib;
    logic                 r_whalf;
    logic [7:0]           r_rbuf;
    logic                 r_rhi;
    logic                 r_re_d1;
    logic                 r_oe;
    logic [3:0]           r_out;
    logic                 r_re;
    logic                 r_we;
    logic [7:0]           r_wdata;

    logic       w_sck;
    logic       w_cs;
    logic [3:0] w_io;
    logic       w_rise;
    logic       w_fall;
    logic       w_cs_fall;
    logic [7:0] w_cmd;

    assign w_sck     = r_sck_sync[1];
    assign w_cs      = r_cs_sync[1];
    assign w_io      = r_io_sync1;
    assign w_rise    = w_sck & ~r_sck_prev;
    assign w_fall    = ~w_sck & r_sck_prev;
    assign w_cs_fall = ~w_cs & r_cs_prev;
    assign w_cmd     = {r_cmd_hi, w_io};

    assign bus.spi_io_out = r_out;
    assign bus.spi_io_oe  = {4{r_oe}};
    assign bus.mem_addr   = r_addr;
    assign bus.mem_re     = r_re;
    assign bus.mem_we     = r_we;
    assign bus.mem_wdata  = r_wdata;

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return JEDEC_ID[23:16];
            2'd1:    return JEDEC_ID[15:8];
            2'd2:    return JEDEC_ID[7:0];
            default: return 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sck_sync <= 2'b00;
            r_cs_sync  <= 2'b11;
            r_io_sync0 <= 4'h0;
            r_io_sync1 <= 4'h0;
            r_sck_prev <= 1'b0;
            r_cs_prev  <= 1'b1;
            r_cnt      <= 8'd0;
            r_cmd_hi   <= 4'h0;
            r_write    <= 1'b0;
            r_id_mode  <= 1'b0;
            r_id_idx   <= 2'd0;
            r_addr     <= '0;
            r_wnib     <= 4'h0;
            r_whalf    <= 1'b0;
            r_rbuf     <= 8'h00;
            r_rhi      <= 1'b1;
            r_re_d1    <= 1'b0;
            r_oe       <= 1'b0;
            r_out      <= 4'h0;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= 8'h00;
        end else begin
            r_sck_sync <= {r_sck_sync[0], bus.spi_sck};
            r_cs_sync  <= {r_cs_sync[0], bus.spi_cs_n};
            r_io_sync0 <= bus.spi_io_in;
            r_io_sync1 <= r_io_sync0;
            r_sck_prev <= w_sck;
            r_cs_prev  <= w_cs;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_re_d1    <= r_re;
            if (r_re_d1) begin
                r_rbuf <= bus.mem_rdata;
            end
            // The write strobe cycle uses the current address; advance after it.
            if (r_we) begin
                r_addr <= r_addr + ADDR_BITS'(1);
            end

            // CS high outranks any SCK edge seen in the same clock.
            if (w_cs && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_oe    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= S_CMD;
                            r_cnt     <= 8'd0;
                            r_addr    <= '0;
                            r_whalf   <= 1'b0;
                            r_rhi     <= 1'b1;
                            r_id_mode <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (w_rise) begin
                            r_cmd_hi <= w_io;
                            r_cnt    <= r_cnt + 8'd1;
                            if (r_cnt == 8'd1) begin
                                r_cnt <= 8'd0;
                                if (w_cmd == c_CMD_READ) begin
                                    r_state <= S_ADDR;
                                    r_write <= 1'b0;
                                end else if (w_cmd == c_CMD_WRITE) begin
                                    r_state <= S_ADDR;
                                    r_write <= 1'b1;
                                end else if (c_ID_EN && (w_cmd == c_CMD_ID)) begin
                                    r_state   <= S_RDATA;
                                    r_id_mode <= 1'b1;
                                    r_rbuf    <= id_byte(2'd0);
                                    r_id_idx  <= 2'd1;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_rise) begin
                            r_addr <= ADDR_BITS'({r_addr, w_io});
                            r_cnt  <= r_cnt + 8'd1;
                            if (r_cnt == 8'd5) begin
                                r_cnt <= 8'd0;
                                if (r_write) begin
                                    r_state <= S_WDATA;
                                end else begin
                                    r_state <= S_DUMMY;
                                    r_re    <= 1'b1;
                                end
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (w_rise) begin
                            r_cnt <= r_cnt + 8'd1;
                            if (r_cnt == 8'(DUMMY_NIBBLES - 1)) begin
                                r_state <= S_RDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_fall) begin
                            r_oe <= 1'b1;
                            if (r_rhi) begin
                                r_out <= r_rbuf[7:4];
                                r_rhi <= 1'b0;
                            end else begin
                                r_out <= r_rbuf[3:0];
                                r_rhi <= 1'b1;
                                if (r_id_mode) begin
                                    r_rbuf <= id_byte(r_id_idx);
                                    if (r_id_idx != 2'd3) begin
                                        r_id_idx <= r_id_idx + 2'd1;
                                    end
                                end else begin
                                    r_addr <= r_addr + ADDR_BITS'(1);
                                    r_re   <= 1'b1;
                                end
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_rise) begin
                            if (!r_whalf) begin
                                r_wnib  <= w_io;
                                r_whalf <= 1'b1;
                            end else begin
                                r_wdata <= {r_wnib, w_io};
                                r_we    <= 1'b1;
                                r_whalf <= 1'b0;
                            end
                        end
                    end
                    S_IGNORE: begin
                        r_oe <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
